// File: rtl/piano_pkg.sv
// Shared state, mode, note and ROM-field definitions for the piano datapath.
// The LEARN_WAIT state exists only when PLAY_SEQ_LEARN_EN is defined.
package piano_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_WAIT_ROM   = 3'd2,
      S_PLAY       = 3'd3,
      S_GAP        = 3'd4,
`ifdef PLAY_SEQ_LEARN_EN
      S_LEARN_WAIT = 3'd5,
`endif
      S_DONE       = 3'd6
   } seq_state_t;

   typedef enum logic [2:0] {
      MODE_IDLE  = 3'b000,
      MODE_LEARN = 3'b001,
      MODE_AUTO  = 3'b010,
      MODE_FREE  = 3'b100
   } mode_t;

   typedef enum logic [3:0] {
      REST = 4'd0,
      DO   = 4'd1,
      RE   = 4'd2,
      MI   = 4'd3,
      FA   = 4'd4,
      SOL  = 4'd5,
      LA   = 4'd6,
      SI   = 4'd7
   } note_t;

   // ROM entry layout: {note[3:0], octave[1:0], dur[5:0]}
   localparam int ROM_W    = 12;
   localparam int NOTE_LSB = 8;
   localparam int NOTE_W   = 4;
   localparam int OCT_LSB  = 6;
   localparam int OCT_W    = 2;
   localparam int DUR_LSB  = 0;
   localparam int DUR_W    = 6;

   function automatic logic [6:0] note_onehot(input logic [3:0] note);
      logic [6:0] oh;
      oh = '0;
      if (note >= 4'(DO) && note <= 4'(SI))
         oh = 7'b1 << (note - 4'd1);
      return oh;
   endfunction

   function automatic logic [3:0] lowest_note(input logic [6:0] k);
      logic [3:0] n;
      n = 4'(REST);
      for (int i = 6; i >= 0; i--)
         if (k[i]) n = 4'(i + 1);
      return n;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Duration-tick divider: one-cycle strobe every DIV cycles, held at zero while restart is high.
module tick_gen #(
   parameter int DIV = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (restart || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/play_sequencer.sv
// Piano sequencer: live keys (free), ROM song playback (auto) and key-gated playback (learn).
// Learn mode is compiled in only when PLAY_SEQ_LEARN_EN is defined; otherwise mode 001 is idle.
module play_sequencer
   import piano_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int NUM_SONGS = 4,
   parameter int SONG_LEN  = 64,
   parameter int GAP_TICKS = 5,
   localparam int SONG_W   = $clog2(NUM_SONGS),
   localparam int STEP_W   = $clog2(SONG_LEN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               mode,
   input  logic [6:0]               keys,
   input  logic [1:0]               octave,
   input  logic [1:0]               song_select,
   output logic [SONG_W+STEP_W-1:0] rom_addr,
   input  logic [ROM_W-1:0]         rom_data,
   output logic [3:0]               note_out,
   output logic [1:0]               octave_out,
   output logic [6:0]               led_out,
   output logic [3:0]               song_num,
   output logic                     busy
);

   localparam int TCNT_W = ($clog2(GAP_TICKS + 1) > DUR_W) ? $clog2(GAP_TICKS + 1) : DUR_W;
   localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

   seq_state_t        state;
   logic [2:0]        mode_q;
   logic [6:0]        keys_s1, keys_s2;
   logic [1:0]        sel_s1, sel_s2, sel_q;
   logic [SONG_W-1:0] song;
   logic [STEP_W-1:0] step;
   logic [TCNT_W-1:0] tick_cnt;
   logic [DUR_W-1:0]  dur_q;

   logic [3:0]        rom_note_raw, rom_note;
   logic [1:0]        rom_oct;
   logic [DUR_W-1:0]  rom_dur;
   logic [1:0]        sel_rise;
   logic              song_chg;
   logic [SONG_W-1:0] song_next;
   logic [STEP_W-1:0] step_inc;
   logic [TCNT_W-1:0] play_last;
   logic              is_free, is_auto, is_learn;
   logic              tick, tick_restart;

   assign rom_note_raw = rom_data[NOTE_LSB +: NOTE_W];
   assign rom_note     = (rom_note_raw > 4'(SI)) ? 4'(REST) : rom_note_raw;
   assign rom_oct      = rom_data[OCT_LSB +: OCT_W];
   assign rom_dur      = rom_data[DUR_LSB +: DUR_W];

   assign sel_rise  = sel_s2 & ~sel_q;
   assign song_chg  = sel_rise[0] ^ sel_rise[1];
   assign song_next = sel_rise[0] ? song + 1'b1 : song - 1'b1;
   assign step_inc  = step + 1'b1;
   assign play_last = TCNT_W'(dur_q) - 1'b1;
   assign song_num  = 4'(song);

   assign is_free = (mode == MODE_FREE);
   assign is_auto = (mode == MODE_AUTO);
`ifdef PLAY_SEQ_LEARN_EN
   assign is_learn = (mode == MODE_LEARN);
`else
   assign is_learn = 1'b0;
`endif

   // PLAY ends exactly on a tick, so the divider wraps to zero on entry to GAP by itself
   assign tick_restart = (state != S_PLAY) && (state != S_GAP);

   tick_gen #(
      .DIV(CLK_HZ / TICK_HZ)
   ) u_tick_gen (
      .clk(clk),
      .reset(reset),
      .restart(tick_restart),
      .tick(tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keys_s1 <= '0;
         keys_s2 <= '0;
         sel_s1  <= '0;
         sel_s2  <= '0;
         sel_q   <= '0;
      end else begin
         keys_s1 <= keys;
         keys_s2 <= keys_s1;
         sel_s1  <= song_select;
         sel_s2  <= sel_s1;
         sel_q   <= sel_s2;
      end
   end

`ifdef PLAY_SEQ_LEARN_EN
   logic [6:0] keys_q;
   logic [6:0] key_rise;
   logic [3:0] note_q;
   logic [1:0] oct_q;

   assign key_rise = keys_s2 & ~keys_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) keys_q <= '0;
      else       keys_q <= keys_s2;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         mode_q     <= '0;
         song       <= '0;
         step       <= '0;
         tick_cnt   <= '0;
         dur_q      <= '0;
         rom_addr   <= '0;
         note_out   <= 4'(REST);
         octave_out <= '0;
         led_out    <= '0;
         busy       <= 1'b0;
`ifdef PLAY_SEQ_LEARN_EN
         note_q     <= 4'(REST);
         oct_q      <= '0;
`endif
      end else begin
         mode_q <= mode;
         if (mode != mode_q || song_chg) begin
            // Both mode and song changes restart the sequence from step 0 in silence
            if (mode == mode_q) song <= song_next;
            state    <= S_IDLE;
            step     <= '0;
            note_out <= 4'(REST);
            led_out  <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (is_free) begin
                     note_out   <= lowest_note(keys_s2);
                     octave_out <= octave;
                     led_out    <= keys_s2;
                     busy       <= 1'b0;
                  end else if (is_auto || is_learn) begin
                     state    <= S_FETCH;
                     rom_addr <= {song, step};
                     note_out <= 4'(REST);
                     led_out  <= '0;
                     busy     <= 1'b1;
                  end else begin
                     note_out <= 4'(REST);
                     led_out  <= '0;
                     busy     <= 1'b0;
                  end
               end

               S_FETCH: state <= S_WAIT_ROM;

               S_WAIT_ROM: begin
                  dur_q <= rom_dur;
`ifdef PLAY_SEQ_LEARN_EN
                  note_q <= rom_note;
                  oct_q  <= rom_oct;
`endif
                  if (rom_dur == '0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
`ifdef PLAY_SEQ_LEARN_EN
                  end else if (is_learn && rom_note != 4'(REST)) begin
                     state    <= S_LEARN_WAIT;
                     note_out <= 4'(REST);
                     led_out  <= note_onehot(rom_note);
`endif
                  end else begin
                     state      <= S_PLAY;
                     tick_cnt   <= '0;
                     note_out   <= rom_note;
                     octave_out <= rom_oct;
                     led_out    <= note_onehot(rom_note);
                  end
               end

`ifdef PLAY_SEQ_LEARN_EN
               S_LEARN_WAIT: begin
                  if ((key_rise & note_onehot(note_q)) != '0) begin
                     state      <= S_PLAY;
                     tick_cnt   <= '0;
                     note_out   <= note_q;
                     octave_out <= oct_q;
                  end
               end
`endif

               S_PLAY: begin
                  if (tick) begin
                     if (tick_cnt == play_last) begin
                        state    <= S_GAP;
                        tick_cnt <= '0;
                        note_out <= 4'(REST);
                        led_out  <= '0;
                     end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end
                  end
               end

               S_GAP: begin
                  if (tick) begin
                     if (tick_cnt == GAP_LAST) begin
                        tick_cnt <= '0;
                        if (&step) begin
                           state <= S_DONE;
                           busy  <= 1'b0;
                        end else begin
                           state    <= S_FETCH;
                           step     <= step_inc;
                           rom_addr <= {song, step_inc};
                        end
                     end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end
                  end
               end

               S_DONE: begin
                  note_out <= 4'(REST);
                  led_out  <= '0;
                  busy     <= 1'b0;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer: free, auto, song select, async reset and learn mode
// (learn expectations follow whether PLAY_SEQ_LEARN_EN is defined).
module tb_play_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  mode = 3'b000;
   logic [6:0]  keys = '0;
   logic [1:0]  octave = '0;
   logic [1:0]  song_select = '0;
   logic [7:0]  rom_addr;
   logic [11:0] rom_data = '0;
   logic [3:0]  note_out;
   logic [1:0]  octave_out;
   logic [6:0]  led_out;
   logic [3:0]  song_num;
   logic        busy;

   logic [11:0] rom [0:255];

   int checks = 0;
   int failures = 0;

   play_sequencer #(
      .CLK_HZ(1000),
      .TICK_HZ(100),
      .NUM_SONGS(4),
      .SONG_LEN(64),
      .GAP_TICKS(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mode(mode),
      .keys(keys),
      .octave(octave),
      .song_select(song_select),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .note_out(note_out),
      .octave_out(octave_out),
      .led_out(led_out),
      .song_num(song_num),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_note(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step(1);
         if (note_out != 4'd0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_len(input logic [3:0] val, output int n);
      n = 0;
      while (note_out == val && n < 200) begin
         n++;
         step(1);
      end
   endtask

   task automatic press(input logic [1:0] v);
      song_select = v;
      step(1);
      song_select = 2'b00;
      step(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;

      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[0] = {4'd1, 2'd1, 6'd2};
      rom[1] = {4'd5, 2'd2, 6'd3};
      rom[2] = {4'd0, 2'd0, 6'd0};

      // reset values
      #1 reset = 1'b1;
      #3;
      check("rst_note", 32'(note_out), 32'd0);
      check("rst_oct", 32'(octave_out), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_song", 32'(song_num), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      step(2);
      reset = 1'b0;

      // free mode
      mode = 3'b100;
      octave = 2'd2;
      step(3);
      keys = 7'b0010100;
      step(2);
      check("free_lat2", 32'(note_out), 32'd0);
      step(1);
      check("free_note", 32'(note_out), 32'd3);
      check("free_led", 32'(led_out), 32'b0010100);
      check("free_oct", 32'(octave_out), 32'd2);
      check("free_busy", 32'(busy), 32'd0);
      keys = 7'b0000000;
      step(3);
      check("free_off_note", 32'(note_out), 32'd0);
      check("free_off_led", 32'(led_out), 32'd0);

      // auto mode playback of song 0
      mode = 3'b010;
      wait_note(20, ok);
      check("auto_start", 32'(ok), 32'd1);
      check("auto_n1", 32'(note_out), 32'd1);
      check("auto_o1", 32'(octave_out), 32'd1);
      check("auto_l1", 32'(led_out), 32'b0000001);
      check("auto_busy", 32'(busy), 32'd1);
      run_len(4'd1, n);
      check("auto_len1", 32'(n), 32'd20);
      check("auto_gap_busy", 32'(busy), 32'd1);
      run_len(4'd0, n);
      check("auto_gap1", 32'(n), 32'd12);
      check("auto_n2", 32'(note_out), 32'd5);
      check("auto_o2", 32'(octave_out), 32'd2);
      check("auto_l2", 32'(led_out), 32'b0010000);
      run_len(4'd5, n);
      check("auto_len2", 32'(n), 32'd30);
      step(20);
      check("done_note", 32'(note_out), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("done_led", 32'(led_out), 32'd0);
      check("done_addr", 32'(rom_addr), 32'd2);
      step(30);
      check("done_hold_note", 32'(note_out), 32'd0);
      check("done_hold_busy", 32'(busy), 32'd0);

      // song select
      mode = 3'b000;
      step(3);
      for (int i = 0; i < 5; i++) press(2'b01);
      check("sel_next5", 32'(song_num), 32'd1);
      press(2'b11);
      check("sel_both", 32'(song_num), 32'd1);
      press(2'b10);
      check("sel_prev", 32'(song_num), 32'd0);
      press(2'b10);
      check("sel_prev_wrap", 32'(song_num), 32'd3);
      press(2'b01);
      check("sel_next_wrap", 32'(song_num), 32'd0);

      // asynchronous reset during PLAY, then restart from step 0
      mode = 3'b010;
      wait_note(20, ok);
      check("rp_start", 32'(ok), 32'd1);
      check("rp_note", 32'(note_out), 32'd1);
      step(5);
      #2 reset = 1'b1;
      #1;
      check("rp_rst_note", 32'(note_out), 32'd0);
      check("rp_rst_oct", 32'(octave_out), 32'd0);
      check("rp_rst_led", 32'(led_out), 32'd0);
      check("rp_rst_busy", 32'(busy), 32'd0);
      check("rp_rst_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      wait_note(20, ok);
      check("rp_restart", 32'(ok), 32'd1);
      check("rp_restart_note", 32'(note_out), 32'd1);
      run_len(4'd1, n);
      check("rp_restart_len", 32'(n), 32'd20);

      // learn mode
      mode = 3'b000;
      step(3);
      rom[0] = {4'd3, 2'd1, 6'd2};
      rom[1] = '0;
      mode = 3'b001;
      step(10);
`ifdef PLAY_SEQ_LEARN_EN
      check("learn_led", 32'(led_out), 32'b0000100);
      check("learn_note", 32'(note_out), 32'd0);
      check("learn_busy", 32'(busy), 32'd1);
      step(50);
      check("learn_hold_led", 32'(led_out), 32'b0000100);
      check("learn_hold_note", 32'(note_out), 32'd0);
      keys = 7'b0000001;
      step(6);
      check("learn_wrong_note", 32'(note_out), 32'd0);
      check("learn_wrong_led", 32'(led_out), 32'b0000100);
      keys = 7'b0000000;
      step(4);
      keys = 7'b0000100;
      wait_note(10, ok);
      check("learn_hit", 32'(ok), 32'd1);
      check("learn_hit_note", 32'(note_out), 32'd3);
      check("learn_hit_oct", 32'(octave_out), 32'd1);
      run_len(4'd3, n);
      check("learn_len", 32'(n), 32'd20);
      keys = 7'b0000000;
      step(20);
      check("learn_done_busy", 32'(busy), 32'd0);
`else
      check("nolearn_note", 32'(note_out), 32'd0);
      check("nolearn_led", 32'(led_out), 32'd0);
      check("nolearn_busy", 32'(busy), 32'd0);
      keys = 7'b0000100;
      step(10);
      check("nolearn_key_note", 32'(note_out), 32'd0);
      check("nolearn_key_led", 32'(led_out), 32'd0);
      keys = 7'b0000000;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
